// File: rtl/input_decoder_fifo.sv
// First-word-fall-through FIFO between upstream command producers and the
// input decoder. Head word is read combinationally; empty/full are registered.
module input_decoder_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] DEPTH_COUNT = PTR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [PTR_WIDTH-1:0] rptr_reg, rptr_next;
  logic [PTR_WIDTH-1:0] count_reg, count_next;
  logic                 empty_reg, empty_next;
  logic                 full_reg, full_next;
  logic                 push;
  logic                 pop;

  // Acceptance uses the registered flags, so a read on empty or a write on
  // full is simply dropped while the other request still proceeds.
  assign push = write & ~full_reg;
  assign pop  = read & ~empty_reg;

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    if (push) begin
      wptr_next = wptr_reg + PTR_ONE;
    end
    if (pop) begin
      rptr_next = rptr_reg + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + PTR_ONE;
      2'b01:   count_next = count_reg - PTR_ONE;
      default: count_next = count_reg;
    endcase
    empty_next = (count_next == '0);
    full_next  = (count_next == DEPTH_COUNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      empty_reg <= empty_next;
      full_reg  <= full_next;
    end
  end

  // Storage has no reset; stale words become unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_reg[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

  assign r_data = mem[rptr_reg[ADDR_WIDTH-1:0]];
  assign empty  = empty_reg;
  assign full   = full_reg;

endmodule

// File: tb/tb_input_decoder_fifo.sv
// Self-checking bench for input_decoder_fifo: directed vector table, hand-written
// fill/overflow/wrap/reset sequences, then random traffic against a queue model.
module tb_input_decoder_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        write;
  logic        read;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        empty;
  logic        full;

  int tests;
  int fails;
  logic [31:0] model_q[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] d;
    logic        exp_empty;
    logic        exp_full;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  input_decoder_fifo dut (
    .clk    (clk),
    .reset  (reset),
    .write  (write),
    .read   (read),
    .w_data (w_data),
    .r_data (r_data),
    .empty  (empty),
    .full   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, update the queue model, and sample after the edge.
  task automatic step(input logic wr, input logic rd, input logic [31:0] d);
    bit do_push;
    bit do_pop;
    write  = wr;
    read   = rd;
    w_data = d;
    do_push = wr && (model_q.size() < DEPTH);
    do_pop  = rd && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_empty"}, {31'd0, empty}, {31'd0, model_q.size() == 0});
    check({tag, "_full"}, {31'd0, full}, {31'd0, model_q.size() == DEPTH});
    if (model_q.size() > 0) check({tag, "_rdata"}, r_data, model_q[0]);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_full", {31'd0, full}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b0;
    write  = 1'b0;
    read   = 1'b0;
    w_data = '0;

    vecs[0] = '{1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 1'b0, 32'd0};
    vecs[1] = '{1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 1'b0, 32'd0};
    vecs[2] = '{1'b1, 1'b0, 32'd1,          1'b0, 1'b0, 1'b1, 32'd1};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 32'd1};
    vecs[4] = '{1'b1, 1'b1, 32'd1000,       1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 1'b1, 32'd0,          1'b0, 1'b0, 1'b1, 32'd1000};
    vecs[6] = '{1'b0, 1'b1, 32'd0,          1'b1, 1'b0, 1'b0, 32'd0};
    vecs[7] = '{1'b0, 1'b1, 32'd0,          1'b1, 1'b0, 1'b0, 32'd0};
    vecs[8] = '{1'b1, 1'b1, 32'hA5A5_0055,  1'b0, 1'b0, 1'b1, 32'hA5A5_0055};
    vecs[9] = '{1'b0, 1'b1, 32'd0,          1'b1, 1'b0, 1'b0, 32'd0};

    // Initial reset, checked while still asserted.
    repeat (2) @(posedge clk);
    #1;
    check("por_empty", {31'd0, empty}, 32'd1);
    check("por_full", {31'd0, full}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].d);
      $display("[TB] vec %0d wr=%0b rd=%0b d=%h -> empty=%0b full=%0b r_data=%h",
               i, vecs[i].wr, vecs[i].rd, vecs[i].d, empty, full, r_data);
      check($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_empty});
      check($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
      if (vecs[i].chk_data) check($sformatf("vec%0d_rdata", i), r_data, vecs[i].exp_data);
    end

    // Fill with 0..7, then an overflow write of 99 must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, i);
      check($sformatf("fill%0d_full", i), {31'd0, full}, {31'd0, i == DEPTH - 1});
    end
    step(1'b1, 1'b0, 32'd99);
    $display("[TB] overflow write 99 -> full=%0b", full);
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_head", r_data, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d_data", i), r_data, i);
      step(1'b0, 1'b1, 32'd0);
    end
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_full", {31'd0, full}, 32'd0);

    // Full, then simultaneous read+write: only the pop happens.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'h100 + i);
    step(1'b1, 1'b1, 32'hDEAD);
    $display("[TB] rw while full -> full=%0b r_data=%h", full, r_data);
    check("rwfull_full", {31'd0, full}, 32'd0);
    check("rwfull_head", r_data, 32'h101);

    // Wrap-around: interleave pushes and pops past the array end.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 32'h200 + i);
      check_model($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'd0);
      check_model($sformatf("wrappop%0d", i));
    end

    // Asynchronous reset mid-stream, then confirm stale data is unreachable.
    do_reset();
    check("post_rst_empty", {31'd0, empty}, 32'd1);
    step(1'b1, 1'b0, 32'h1234_5678);
    $display("[TB] push after reset -> empty=%0b r_data=%h", empty, r_data);
    check("post_rst_data", r_data, 32'h1234_5678);
    check_model("post_rst");

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic wr;
      logic rd;
      logic [31:0] d;
      wr = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      rd = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      d  = $urandom;
      if (i == 450) do_reset();
      step(wr, rd, d);
      $display("[TB] rnd %0d wr=%0b rd=%0b d=%h -> empty=%0b full=%0b r_data=%h",
               i, wr, rd, d, empty, full, r_data);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
